imem_loader: RTL and testbench

// - Writer side of the CPU instruction memory. The CPU core only reads program words.
// - Accepts a byte stream over a valid/ready handshake and assembles 32-bit little-endian words.
// - Writes each word to the instruction RAM write port.
// - Holds the CPU in reset while a load is in progress.
// - Replaces forcing program/register state from the bench with a synthesizable load path.
//

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the CPU instruction memory.
// Accepts a byte stream (valid/ready), assembles 32-bit little-endian words
// and writes them to the instruction RAM. The CPU is held in reset while a
// load is in progress and is released only after a good image.
//
// Frame: LEN_LO, LEN_HI (N words), 4*N data bytes LSB first,
// [checksum byte when LOADER_CHECKSUM_EN is defined].
//
// Build option: `define LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   start       in   1-cycle pulse, begins a load (only honoured in IDLE)
//   byte_valid  in   source has byte_data available
//   byte_data   in   stream byte
//   byte_ready  out  loader accepts byte_data this cycle
//   mem_we      out  instruction RAM write enable
//   mem_addr    out  RAM word address
//   mem_wdata   out  RAM write word
//   cpu_rst     out  active-high CPU reset, high while loading / after a bad image
//   busy        out  load in progress
//   done        out  1-cycle pulse, load finished without error
//   err         out  sticky error flag, cleared by next start
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    DONE,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    ERR
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [7:0]          len_lo_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    wcnt_q;
  logic [1:0]          bidx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   word_q;
  logic                accept_c;
  logic [LEN_W-1:0]    len_c;
  logic                ready_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_q;
`endif

  assign accept_c  = byte_valid && byte_ready;
  assign len_c     = {byte_data, len_lo_q};
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and ready decode of the upcoming state
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = LEN0;
      LEN0:  if (accept_c) state_d = LEN1;
      LEN1: begin
        if (accept_c) begin
          if (len_c == '0)                    state_d = DONE;
          else if (len_c > LEN_W'(DEPTH))     state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA:  if (accept_c && bidx_q == 2'd3) state_d = WRITE;
      WRITE: begin
        if (wcnt_q + LEN_W'(1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK:   if (accept_c) state_d = (byte_data == xor_q) ? DONE : ERR;
`endif
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      LEN0, LEN1, DATA: ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:              ready_d = 1'b1;
`endif
      default:          ready_d = 1'b0;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      cpu_rst    <= 1'b0;
      err        <= 1'b0;
      len_lo_q   <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      bidx_q     <= '0;
      addr_q     <= '0;
      word_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      byte_ready <= ready_d;
      mem_we     <= (state_d == WRITE);
      done       <= (state_d == DONE);
      busy       <= (state_d != IDLE) && (state_d != DONE) && (state_d != ERR);

      if (state_q == IDLE && start) begin
        cpu_rst <= 1'b1;
        err     <= 1'b0;
        addr_q  <= '0;
        wcnt_q  <= '0;
        bidx_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
        xor_q   <= '0;
`endif
      end
      // cpu_rst deliberately holds after ERR so a bad image never runs
      if (state_d == DONE) cpu_rst <= 1'b0;
      if (state_d == ERR)  err     <= 1'b1;

      if (state_q == LEN0 && accept_c) len_lo_q <= byte_data;
      if (state_q == LEN1 && accept_c) len_q    <= len_c;

      if (state_q == DATA && accept_c) begin
        word_q[{bidx_q, 3'b000} +: 8] <= byte_data;
        bidx_q <= bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        xor_q  <= xor_q ^ byte_data;
`endif
      end

      if (state_q == WRITE) begin
        addr_q <= addr_q + ADDR_W'(1);
        wcnt_q <= wcnt_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the block's test
// list plus randomized frames, compared against a frame-level reference model.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                done_cnt;
  int                rdy_in_write;
  int                cpu_rst_at_done;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Observe RAM writes and done pulses away from the active edge
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (byte_ready) rdy_in_write++;
    end
    if (done) begin
      done_cnt++;
      if (cpu_rst) cpu_rst_at_done++;
    end
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt        = 0;
    rdy_in_write    = 0;
    cpu_rst_at_done = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {byte_ready, mem_we, cpu_rst, busy, done, err}, 6'b0);
    check({tag, "_addr"}, 64'(mem_addr), 64'h0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'h0);
  endtask

  // Drive bytes; mode 0 = always valid, 1 = valid every other cycle, 2 = random.
  // start_at >= 0 raises start for one cycle once that many bytes are accepted.
  task automatic feed(input logic [7:0] bytes[$], input int mode, input int start_at);
    int idx = 0;
    int cyc = 0;
    bit acc;
    bit injected = 0;
    while (idx < bytes.size() && cyc < 5000) begin
      @(negedge clk);
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = cyc[0];
        default: byte_valid = ($urandom_range(0, 2) != 0);
      endcase
      byte_data = byte_valid ? bytes[idx] : 8'($urandom);
      start = 1'b0;
      if (!injected && start_at >= 0 && idx == start_at) begin
        start    = 1'b1;
        injected = 1;
      end
      acc = byte_valid && byte_ready;
      cyc++;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    check("bytes_consumed", 64'(idx), 64'(bytes.size()));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("start_busy", {busy, cpu_rst, err}, 3'b110);
  endtask

  // Reference model: frame bytes and expected outcome from N and word list
  task automatic run_frame(input int n, input logic [31:0] w[$], input int mode,
                           input int start_at, input bit bad_chk);
    logic [7:0]  bytes[$];
    logic [31:0] exp_w[$];
    logic [15:0] n16;
    logic [31:0] cw;
    logic [7:0]  x;
    bit          ok;
    int          cyc;
    n16 = 16'(n);
    ok  = (n <= int'(DEPTH));
    x   = 8'h00;
    bytes.push_back(n16[7:0]);
    bytes.push_back(n16[15:8]);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        cw = w[i];
        exp_w.push_back(cw);
        for (int b = 0; b < 4; b++) begin
          bytes.push_back(cw[8*b +: 8]);
          x = x ^ cw[8*b +: 8];
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (ok && n > 0) begin
      bytes.push_back(bad_chk ? ~x : x);
      if (bad_chk) ok = 0;
    end
`else
    if (bad_chk) $display("note: corrupt trailer has no meaning without checksum build (x=%0h)", x);
`endif
    clear_mon();
    pulse_start();
    feed(bytes, mode, start_at);
    cyc = 0;
    while (done_cnt == 0 && !err && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("end_reached", 64'(cyc < 100), 64'h1);
    repeat (2) @(negedge clk);
    #1;
    check("write_count", 64'(wr_addr.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_addr.size(); i++) begin
      check("write_addr", 64'(wr_addr[i]), 64'(i));
      check("write_data", 64'(wr_data[i]), 64'(exp_w[i]));
    end
    check("done_pulses", 64'(done_cnt), 64'(ok ? 1 : 0));
    check("err_flag", 64'(err), 64'(!ok));
    check("cpu_rst_end", 64'(cpu_rst), 64'(!ok));
    check("busy_end", 64'(busy), 64'h0);
    check("ready_in_write", 64'(rdy_in_write), 64'h0);
    check("cpu_rst_at_done", 64'(cpu_rst_at_done), 64'h0);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  bytes[$];
    int          n;

    // Reset state
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    clear_mon();
    repeat (5) @(negedge clk);
    #1;
    check_all_zero("idle");
    check("idle_writes", 64'(wr_addr.size()), 64'h0);

    // Single word
    w = '{32'hE0823004};
    run_frame(1, w, 0, -1, 0);

    // Three words, valid toggling every other cycle
    w = '{32'($urandom), 32'($urandom), 32'($urandom)};
    run_frame(3, w, 1, -1, 0);

    // Oversize image
    w.delete();
    run_frame(257, w, 0, -1, 0);

    // Empty image
    run_frame(0, w, 0, -1, 0);

    // start pulsed mid-load
    w = '{32'($urandom), 32'($urandom)};
    run_frame(2, w, 2, 5, 0);

    // Full-depth boundary image
    w.delete();
    for (int i = 0; i < int'(DEPTH); i++) w.push_back(32'($urandom));
    run_frame(int'(DEPTH), w, 0, -1, 0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong trailer
    w = '{32'($urandom), 32'($urandom)};
    run_frame(2, w, 0, -1, 1);
`endif

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(257, 2000));
      else                           n = int'($urandom_range(1, 6));
      w.delete();
      for (int i = 0; i < n && i < 8; i++) w.push_back(32'($urandom));
      run_frame(n, w, int'($urandom_range(0, 2)), -1,
`ifdef LOADER_CHECKSUM_EN
                bit'($urandom_range(0, 3) == 0)
`else
                1'b0
`endif
               );
    end

    // Reset mid-load after 6 data bytes
    clear_mon();
    w = '{32'($urandom), 32'($urandom)};
    bytes = '{8'h02, 8'h00};
    for (int b = 0; b < 4; b++) bytes.push_back(8'(w[0] >> (8*b)));
    bytes.push_back(8'($urandom));
    bytes.push_back(8'($urandom));
    pulse_start();
    feed(bytes, 0, -1);
    rst = 1'b0;
    #1;
    check("midrst_outs", {mem_we, cpu_rst, busy, byte_ready, done}, 5'b0);
    check("midrst_writes", 64'(wr_addr.size()), 64'h1);
    if (wr_data.size() > 0) check("midrst_word", 64'(wr_data[0]), 64'(w[0]));
    @(negedge clk);
    rst = 1'b1;

    // Recovery after reset
    w = '{32'($urandom)};
    run_frame(1, w, 2, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
